// File: rtl/mips_pkg.sv
// Shared fetch-path constants: instruction size, PC alignment and counter sizing.
// Latency: none (package only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int unsigned INST_BYTES = 4;

  // Clears the byte-offset bits of a fetch address (slice to XLEN at use site).
  localparam logic [63:0] PC_ALIGN_MASK = ~64'(INST_BYTES - 1);

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of DEPTH entries x WIDTH bits with push, pop and flush.
// Latency: a pushed entry is readable at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && (count != CW'(DEPTH));
  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[head];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generator, in-order imem request/response, prefetch buffer.
// Latency: a response appears on inst_* one cycle after imem_rsp_valid.
// Backpressure: requests stall once buffered plus in-flight instructions reach DEPTH.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [XLEN-1:0]               imem_rsp_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [XLEN-1:0]               inst_data,
  output logic [XLEN-1:0]               inst_pc,
  output logic [cnt_width(DEPTH)-1:0]   fifo_count
);

  localparam int unsigned     CW      = cnt_width(DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN   = PC_ALIGN_MASK[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [CW:0]       inflight;
  logic              req_fire;
  logic              rsp_accept;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // Reserving buffer space at request time means a response always has a slot.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = reset && !redirect_valid && (inflight < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_accept     = imem_rsp_valid && !redirect_valid && (discard == '0);
  assign inst_valid     = (count != '0);
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign fifo_count     = count;
  assign {inst_data, inst_pc} = head;

  // Request and response PCs; a redirect reloads both with the aligned target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN;
      rsp_pc   <= redirect_pc & ALIGN;
    end else begin
      if (req_fire)   fetch_pc <= fetch_pc + STEP;
      if (rsp_accept) rsp_pc   <= rsp_pc + STEP;
    end
  end

  // In-flight and stale-response accounting. On redirect every request still in
  // flight is stale, which already includes any not yet drained from an earlier redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid)                         discard <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && discard != '0)   discard <= discard - 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_accept),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

endmodule
